// File: rtl/hyperbus_resp_pkg.sv
// Shared types for the HyperBus responder: FSM states, command-address layout, byte-lane masks.
package hyperbus_resp_pkg;

   typedef enum logic [2:0] {IDLE, CA, LAT, WDATA, RDATA, REGWR, WAITCS} state_t;

   localparam int unsigned CaRwBit    = 47;
   localparam int unsigned CaSpaceBit = 46;
   localparam int unsigned CaBurstBit = 45;
   localparam int unsigned CaRowMsb   = 44;
   localparam int unsigned CaRowLsb   = 16;
   localparam int unsigned CaColMsb   = 2;

   typedef struct packed {
      logic                         rw;
      logic                         space;
      logic                         burst;
      logic [CaRowMsb-CaRowLsb:0]   row;
      logic [CaRowLsb-CaColMsb-2:0] rsvd;
      logic [CaColMsb:0]            col;
   } ca_t;

   typedef logic [1:0] byte_mask_t;

   // Word address before truncation to the array size: row bits above the 3 column bits.
   function automatic logic [31:0] ca_word(input ca_t ca);
      return {ca.row, ca.col};
   endfunction

endpackage

// File: rtl/hyperbus_resp_if.sv
// HyperBus pin bundle between the controller (master) and the responder (slave).
interface hyperbus_resp_if;
   logic       reset_n;
   logic       cs_n;
   logic       ck;
   logic [7:0] dq_ctrl;
   logic       rwds_ctrl;
   logic [7:0] dq_resp;
   logic       dq_oe;
   logic       rwds_resp;
   logic       rwds_oe;

   modport master (
      output reset_n, cs_n, ck, dq_ctrl, rwds_ctrl,
      input  dq_resp, dq_oe, rwds_resp, rwds_oe
   );

   modport slave (
      input  reset_n, cs_n, ck, dq_ctrl, rwds_ctrl,
      output dq_resp, dq_oe, rwds_resp, rwds_oe
   );
endinterface

// File: rtl/hyperbus_resp_mem.sv
// Word array with per-byte write enables, synchronous write and registered read on one address.
module hyperbus_resp_mem
   import hyperbus_resp_pkg::*;
#(
   parameter int unsigned MemWords = 4096
) (
   input  logic                        clk,
   input  logic                        we,
   input  byte_mask_t                  be,
   input  logic [$clog2(MemWords)-1:0] addr,
   input  logic [15:0]                 wdata,
   output logic [15:0]                 rdata
);
   logic [7:0] hi_mem [MemWords];
   logic [7:0] lo_mem [MemWords];

   always_ff @(posedge clk) begin
      if (we && be[1]) hi_mem[addr] <= wdata[15:8];
      if (we && be[0]) lo_mem[addr] <= wdata[7:0];
      rdata <= {hi_mem[addr], lo_mem[addr]};
   end
endmodule

// File: rtl/hyperbus_responder.sv
// HyperRAM-style target: oversamples the bus on clk_i, decodes CA, serves memory and one config register.
module hyperbus_responder
   import hyperbus_resp_pkg::*;
#(
   parameter int unsigned MemWords      = 4096,
   parameter int unsigned LatencyClocks = 6,
   parameter logic [15:0] CfgRst        = 16'h8F1F
) (
   input  logic             clk_i,
   input  logic             rst_i,
   hyperbus_resp_if.slave   bus,
   output logic [15:0]      cfg_o,
   output logic             busy_o
);
   localparam int unsigned AW       = $clog2(MemWords);
   localparam int unsigned DataEdge = 6 + 4 * LatencyClocks;
   localparam int unsigned EW       = $clog2(DataEdge + 1);

   logic [1:0] cs_sync, ck_sync, rstn_sync, rwds_sync;
   logic [7:0] dq_s1, dq_s2;
   logic       ck_prev;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cs_sync   <= '1;
         ck_sync   <= '0;
         rstn_sync <= '1;
         rwds_sync <= '0;
         dq_s1     <= '0;
         dq_s2     <= '0;
         ck_prev   <= 1'b0;
      end else begin
         cs_sync   <= {cs_sync[0], bus.cs_n};
         ck_sync   <= {ck_sync[0], bus.ck};
         rstn_sync <= {rstn_sync[0], bus.reset_n};
         rwds_sync <= {rwds_sync[0], bus.rwds_ctrl};
         dq_s1     <= bus.dq_ctrl;
         dq_s2     <= dq_s1;
         ck_prev   <= ck_sync[1];
      end
   end

   logic srst, cs_n, ck_edge, rwds;
   assign srst    = rst_i | ~rstn_sync[1];
   assign cs_n    = cs_sync[1];
   assign ck_edge = ck_sync[1] ^ ck_prev;
   assign rwds    = rwds_sync[1];

   state_t        state;
   logic [EW-1:0] ecnt;
   logic [39:0]   ca_sh;
   logic [AW-1:0] addr, addr_inc;
   logic          is_read, is_reg, linear, lower, hi_mask;
   logic [7:0]    hi_byte, dq_q;
   logic          dq_oe_q, rwds_q, rwds_oe_q;
   logic [15:0]   cfg_q, mem_rdata, rd_word;
   logic          mem_we;
   byte_mask_t    mem_be;

   assign addr_inc = linear ? addr + 1'b1 : {addr[AW-1:4], addr[3:0] + 4'd1};
   assign rd_word  = is_reg ? cfg_q : mem_rdata;

   // The write fires on the lower-byte edge itself so an aborted or reset transfer never commits.
   always_comb begin
      mem_we = 1'b0;
      mem_be = '0;
      if (state == WDATA && ck_edge && lower && !cs_n && !srst) begin
         mem_be = ~{hi_mask, rwds};
         mem_we = |mem_be;
      end
   end

   hyperbus_resp_mem #(.MemWords(MemWords)) u_mem (
      .clk   (clk_i),
      .we    (mem_we),
      .be    (mem_be),
      .addr  (addr),
      .wdata ({hi_byte, dq_s2}),
      .rdata (mem_rdata)
   );

   always_ff @(posedge clk_i) begin
      if (srst) begin
         state     <= IDLE;
         ecnt      <= '0;
         ca_sh     <= '0;
         addr      <= '0;
         is_read   <= 1'b0;
         is_reg    <= 1'b0;
         linear    <= 1'b0;
         lower     <= 1'b0;
         hi_mask   <= 1'b0;
         hi_byte   <= '0;
         dq_q      <= '0;
         dq_oe_q   <= 1'b0;
         rwds_q    <= 1'b0;
         rwds_oe_q <= 1'b0;
         cfg_q     <= CfgRst;
         busy_o    <= 1'b0;
      end else if (state != IDLE && cs_n) begin
         state     <= IDLE;
         dq_q      <= '0;
         dq_oe_q   <= 1'b0;
         rwds_q    <= 1'b0;
         rwds_oe_q <= 1'b0;
         busy_o    <= 1'b0;
      end else begin
         case (state)
            IDLE: if (!cs_n) begin
               state     <= CA;
               ecnt      <= '0;
               lower     <= 1'b0;
               rwds_q    <= 1'b1;
               rwds_oe_q <= 1'b1;
               busy_o    <= 1'b1;
            end
            CA: if (ck_edge) begin
               ca_sh <= {ca_sh[31:0], dq_s2};
               ecnt  <= ecnt + 1'b1;
               if (ecnt == EW'(5)) begin
                  is_read <= ca_sh[CaRwBit-8];
                  is_reg  <= ca_sh[CaSpaceBit-8];
                  linear  <= ca_sh[CaBurstBit-8];
                  addr    <= AW'(ca_word(ca_t'({ca_sh, dq_s2})));
                  state   <= (!ca_sh[CaRwBit-8] && ca_sh[CaSpaceBit-8]) ? REGWR : LAT;
                  if (!ca_sh[CaRwBit-8]) begin
                     rwds_q    <= 1'b0;
                     rwds_oe_q <= 1'b0;
                  end
               end
            end
            LAT: if (ck_edge) begin
               ecnt <= ecnt + 1'b1;
               if (ecnt == EW'(DataEdge - 1)) state <= is_read ? RDATA : WDATA;
            end
            WDATA: if (ck_edge) begin
               lower <= ~lower;
               if (!lower) begin
                  hi_byte <= dq_s2;
                  hi_mask <= rwds;
               end else begin
                  addr <= addr_inc;
               end
            end
            RDATA: if (ck_edge) begin
               lower     <= ~lower;
               dq_oe_q   <= 1'b1;
               rwds_oe_q <= 1'b1;
               if (!lower) begin
                  dq_q   <= rd_word[15:8];
                  rwds_q <= 1'b1;
               end else begin
                  dq_q   <= rd_word[7:0];
                  rwds_q <= 1'b0;
                  addr   <= addr_inc;
               end
            end
            REGWR: if (ck_edge) begin
               lower <= ~lower;
               if (!lower) begin
                  hi_byte <= dq_s2;
               end else begin
                  cfg_q <= {hi_byte, dq_s2};
                  state <= WAITCS;
               end
            end
            WAITCS: ;
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.dq_resp   = dq_q;
   assign bus.dq_oe     = dq_oe_q;
   assign bus.rwds_resp = rwds_q;
   assign bus.rwds_oe   = rwds_oe_q;
   assign cfg_o         = cfg_q;
endmodule
